// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton row streamer.
// Optional macro CA_ROW_HDR_EN adds a generation header byte to each frame.
package ca_pkg;

    localparam int unsigned ROW_W     = 32;
    localparam int unsigned ROW_BYTES = 4;
    localparam int unsigned GEN_W     = 8;
    localparam int unsigned IDX_W     = 3;

`ifdef CA_ROW_HDR_EN
    localparam int unsigned FRAME_BYTES = ROW_BYTES + 1;
`else
    localparam int unsigned FRAME_BYTES = ROW_BYTES;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
`ifdef CA_ROW_HDR_EN
        logic [GEN_W-1:0] gen;
`endif
        logic [ROW_W-1:0] row;
    } row_entry_t;

    // Byte idx of the outgoing frame for a buffered entry
    function automatic logic [7:0] frame_byte(input row_entry_t e, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
`ifdef CA_ROW_HDR_EN
            3'd0:    b = e.gen;
            3'd1:    b = e.row[7:0];
            3'd2:    b = e.row[15:8];
            3'd3:    b = e.row[23:16];
            3'd4:    b = e.row[31:24];
`else
            3'd0:    b = e.row[7:0];
            3'd1:    b = e.row[15:8];
            3'd2:    b = e.row[23:16];
            3'd3:    b = e.row[31:24];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ca_row_fifo.sv
// Synchronous FIFO of row entries; push is ignored when full, pop when empty.
module ca_row_fifo
    import ca_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  row_entry_t             din,
    output row_entry_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    row_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ca_row_stream.sv
// Buffers automaton rows and serializes them LSB-byte-first onto an 8-bit
// valid/ready stream. Define CA_ROW_HDR_EN to prefix each frame with the
// generation number captured when the row was pushed.
module ca_row_stream
    import ca_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W-1:0]       row,
    input  logic                   row_valid,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    logic [GEN_W-1:0] gen_q;
    row_entry_t       push_entry;
    row_entry_t       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    row_entry_t       ent_q;
    row_entry_t       ent_d;
    logic [7:0]       data_d;
    logic             valid_d;
    logic             last;

    // Entry written to the FIFO: current row tagged with the pre-increment generation
    always_comb begin
        push_entry     = '0;
`ifdef CA_ROW_HDR_EN
        push_entry.gen = gen_q;
`endif
        push_entry.row = row;
    end

    ca_row_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (row_valid),
        .pop   (pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Generation counter and sticky overflow; a drop outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (row_valid) begin
                gen_q <= gen_q + GEN_W'(1);
            end
            if (row_valid && fifo_full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign last = (idx_q == IDX_W'(FRAME_BYTES - 1));
    assign busy = (state_q == SEND);

    // Serializer next state: load from FIFO when idle or after the last byte, else step bytes
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ent_d   = ent_q;
        data_d  = m_data;
        valid_d = m_valid;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ent_d   = fifo_dout;
                    idx_d   = '0;
                    data_d  = frame_byte(fifo_dout, '0);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (!last) begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = frame_byte(ent_q, idx_q + IDX_W'(1));
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        ent_d  = fifo_dout;
                        idx_d  = '0;
                        data_d = frame_byte(fifo_dout, '0);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Serializer registers; reset discards any partially sent row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ent_q   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ent_q   <= ent_d;
            m_data  <= data_d;
            m_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_ca_row_stream.sv
// Self-checking bench for ca_row_stream: directed scenarios plus a randomized
// run against a queue-based reference model. Honors CA_ROW_HDR_EN.
`timescale 1ns/1ps
module tb_ca_row_stream;
    import ca_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned FB    = FRAME_BYTES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   row = '0;
    logic          row_valid = 1'b0;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Reference model state: FIFO of {gen,row}, bytes of the frame in flight
    logic [7:0]  mgen;
    logic [39:0] mfifo[$];
    logic [7:0]  mbytes[$];
    logic        movf;

    ca_row_stream #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .row_valid (row_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Frame bytes for one stored entry
    function automatic void model_load(input logic [39:0] e);
`ifdef CA_ROW_HDR_EN
        mbytes.push_back(e[39:32]);
`endif
        for (int k = 0; k < 4; k++) mbytes.push_back(e[8*k +: 8]);
    endfunction

    // Expected frame appended to the directed-test scoreboard
    function automatic void expect_row(input logic [7:0] g, input logic [31:0] r);
`ifdef CA_ROW_HDR_EN
        exp_q.push_back(g);
`endif
        for (int k = 0; k < 4; k++) exp_q.push_back(r[8*k +: 8]);
    endfunction

    // Behavioural model: one transfer per clock edge from the documented rules
    always @(posedge clk or posedge rst) begin : model
        int   pre_n;
        logic drop;
        if (rst) begin
            mgen = 8'h00;
            mfifo.delete();
            mbytes.delete();
            movf = 1'b0;
        end else begin
            pre_n = mfifo.size();
            if (mbytes.size() > 0 && m_ready) void'(mbytes.pop_front());
            drop = row_valid && (pre_n == DEPTH);
            if (mbytes.size() == 0 && pre_n > 0) model_load(mfifo.pop_front());
            if (row_valid && !drop) mfifo.push_back({mgen, row});
            if (row_valid) mgen = mgen + 8'd1;
            if (drop) movf = 1'b1;
            else if (ovf_clr) movf = 1'b0;
        end
    end

    // Drive one cycle of inputs at the falling edge and log the byte that will hand off
    task automatic step(input logic rv, input logic [31:0] r, input logic rdy, input logic clr);
        @(negedge clk);
        row_valid = rv;
        row       = r;
        m_ready   = rdy;
        ovf_clr   = clr;
        if (!rst && m_valid && m_ready) got_q.push_back(m_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; row_valid = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++; if (level !== LW'(0)) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] first;
`ifdef CA_ROW_HDR_EN
        first = 8'h00;
`else
        first = 8'h78;
`endif
        do_reset();
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (level !== LW'(1)) begin failures++; $display("FAIL single_level_n1 got=%0d exp=1", level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n1 got=%b exp=0", m_valid); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid_n2 got=%b exp=1", m_valid); end
        checks++; if (m_data !== first) begin failures++; $display("FAIL single_byte0 got=%h exp=%h", m_data, first); end
        for (int c = 0; c < 20 && got_q.size() < FB; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        expect_row(8'h00, 32'h1234_5678);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] first;
        int         held_bad;
`ifdef CA_ROW_HDR_EN
        first = 8'h00;
`else
        first = 8'h78;
`endif
        held_bad = 0;
        do_reset();
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            if (m_valid !== 1'b1 || m_data !== first) held_bad++;
        end
        checks++; if (held_bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 last_data=%h exp=%h", held_bad, m_data, first); end
        for (int c = 0; c < 20 && got_q.size() < FB; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        expect_row(8'h00, 32'h1234_5678);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r[6];
        logic [7:0]  first;
        do_reset();
        for (int i = 0; i < 6; i++) r[i] = $urandom;
        for (int i = 0; i < 6; i++) step(1'b1, r[i], 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef CA_ROW_HDR_EN
        first = 8'h00;
`else
        first = r[0][7:0];
`endif
        checks++; if (level !== LW'(DEPTH)) begin failures++; $display("FAIL ovf_level got=%0d exp=%0d", level, DEPTH); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy got=%b exp=1", busy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (m_data !== first) begin failures++; $display("FAIL ovf_head got=%h exp=%h", m_data, first); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        step(1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        checks++; if (level !== LW'(DEPTH)) begin failures++; $display("FAIL ovf_level2 got=%0d exp=%0d", level, DEPTH); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear2 got=%b exp=0", overflow); end
        for (int i = 0; i < 5; i++) expect_row(8'(i), r[i]);
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r[3];
        int          started;
        int          gaps;
        started = 0;
        gaps    = 0;
        do_reset();
        for (int i = 0; i < 3; i++) r[i] = $urandom;
        for (int c = 0; c < 60 && got_q.size() < 3 * FB; c++) begin
            step((c == 0 || c == 2 || c == 4), r[(c / 2) % 3], 1'b1, 1'b0);
            if (m_valid) started = 1;
            else if (started != 0) gaps++;
        end
        for (int i = 0; i < 3; i++) expect_row(8'(i), r[i]);
        checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hdr_wrap();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            r = $urandom;
            expect_row(8'(i), r);
            step(1'b1, r, 1'b1, 1'b0);
            for (int c = 0; c < FB + 1; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] second;
`ifdef CA_ROW_HDR_EN
        second = 8'h78;
`else
        second = 8'h56;
`endif
        do_reset();
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (m_data !== second) begin failures++; $display("FAIL midrst_byte1 got=%h exp=%h", m_data, second); end
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", m_data); end
        checks++; if (level !== LW'(0)) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        step(1'b1, 32'hCAFE_BABE, 1'b1, 1'b0);
        for (int c = 0; c < 20 && got_q.size() < FB; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        expect_row(8'h00, 32'hCAFE_BABE);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic rv;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rv = (c < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            step(rv, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            checks++; if (m_valid !== (mbytes.size() > 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, m_valid, mbytes.size() > 0); end
            if (mbytes.size() > 0) begin
                checks++; if (m_data !== mbytes[0]) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, m_data, mbytes[0]); end
            end
            checks++; if (level !== LW'(mfifo.size())) begin failures++; $display("FAIL rand_level c=%0d got=%0d exp=%0d", c, level, mfifo.size()); end
            checks++; if (busy !== (mbytes.size() > 0)) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, mbytes.size() > 0); end
            checks++; if (overflow !== movf) begin failures++; $display("FAIL rand_overflow c=%0d got=%b exp=%b", c, overflow, movf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_hdr_wrap();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
